chess_board_render: RTL and testbench

Parametrised board-rendering pipeline between the VGA timing generator and the board-state memory. Per active pixel it resolves the board square under the pixel, fetches that row's packed piece word from synchronous board memory (one-cycle read latency), and produces RGB. Adds screen flipping, a blinking cursor and a selected-square highlight. The board size, square size, placement and memory packing are set by parameters.

---
 rtl/chess_board_render_if.sv | 11 +
 rtl/chess_board_render.sv | 192 +++++++++++++++++++
 tb/tb_chess_board_render.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/chess_board_render_if.sv
// Board-memory read port between the renderer and its synchronous row store.
interface chess_board_render_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] oAddr;
    logic [DATA_W-1:0] iData;

    modport master (output oAddr, input iData);
    modport slave  (input oAddr, output iData);
endinterface

// File: rtl/chess_board_render.sv
// Three-stage board renderer: square resolve / piece extract / colour,
// with frame-latched flip, blinking cursor and selected-square highlight.
module chess_board_render #(
    parameter int BOARD_N    = 8,
    parameter int SQ_LOG2    = 5,
    parameter int X_OFFSET   = 64,
    parameter int Y_OFFSET   = 0,
    parameter int PIECE_W    = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int BASE_ADDR  = 0,
    parameter int INSET      = 6,
    parameter int BLINK_LOG2 = 5
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iValid,
    input  logic [9:0]  iX,
    input  logic [9:0]  iY,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iFrameStart,
    input  logic        iFlip,
    input  logic        iCursorEn,
    input  logic [2:0]  iCursorRow,
    input  logic [2:0]  iCursorCol,
    input  logic        iSelEn,
    input  logic [2:0]  iSelRow,
    input  logic [2:0]  iSelCol,
    chess_board_render_if.master mem,
    output logic        oValid,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic        oHS,
    output logic        oVS
);
    localparam int SQ    = 1 << SQ_LOG2;
    localparam int RC_W  = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
    localparam int X_END = X_OFFSET + (BOARD_N << SQ_LOG2);
    localparam int Y_END = Y_OFFSET + (BOARD_N << SQ_LOG2);
    localparam int BW    = BLINK_LOG2 + 1;

    typedef logic [RC_W-1:0] rc_t;

    // Frame-latched controls and blink counter
    logic          flip_reg, cur_en_reg, sel_en_reg;
    logic [2:0]    cur_row_reg, cur_col_reg, sel_row_reg, sel_col_reg;
    logic [BW-1:0] blink_reg;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            flip_reg    <= 1'b0;
            cur_en_reg  <= 1'b0;
            sel_en_reg  <= 1'b0;
            cur_row_reg <= '0;
            cur_col_reg <= '0;
            sel_row_reg <= '0;
            sel_col_reg <= '0;
            blink_reg   <= '0;
        end else if (iFrameStart) begin
            flip_reg    <= iFlip;
            cur_en_reg  <= iCursorEn;
            sel_en_reg  <= iSelEn;
            cur_row_reg <= iCursorRow;
            cur_col_reg <= iCursorCol;
            sel_row_reg <= iSelRow;
            sel_col_reg <= iSelCol;
            blink_reg   <= blink_reg + 1'b1;
        end
    end

    // Stage 1: square resolve
    logic [9:0]         dx, dy;
    logic [SQ_LOG2-1:0] lx, ly;
    logic               in_board, border, inset, cursor_hit, sel_hit;
    rc_t                scr_row, scr_col, board_row, board_col;

    assign dx        = iX - 10'(X_OFFSET);
    assign dy        = iY - 10'(Y_OFFSET);
    assign in_board  = (int'(iX) >= X_OFFSET) && (int'(iX) < X_END) &&
                       (int'(iY) >= Y_OFFSET) && (int'(iY) < Y_END);
    assign scr_col   = rc_t'(dx >> SQ_LOG2);
    assign scr_row   = rc_t'(dy >> SQ_LOG2);
    assign board_col = flip_reg ? rc_t'(BOARD_N - 1) - scr_col : scr_col;
    assign board_row = flip_reg ? rc_t'(BOARD_N - 1) - scr_row : scr_row;
    assign lx        = dx[SQ_LOG2-1:0];
    assign ly        = dy[SQ_LOG2-1:0];
    assign border    = (int'(lx) < 2) || (int'(lx) >= SQ - 2) ||
                       (int'(ly) < 2) || (int'(ly) >= SQ - 2);
    assign inset     = (int'(lx) >= INSET) && (int'(lx) <= SQ - 1 - INSET) &&
                       (int'(ly) >= INSET) && (int'(ly) <= SQ - 1 - INSET);
    // Blink and cursor/selection are resolved here so in-flight pixels keep them
    assign cursor_hit = cur_en_reg && !blink_reg[BW-1] && border &&
                        (board_row == rc_t'(cur_row_reg)) && (board_col == rc_t'(cur_col_reg));
    assign sel_hit    = sel_en_reg &&
                        (board_row == rc_t'(sel_row_reg)) && (board_col == rc_t'(sel_col_reg));

    logic s1_in_reg, s1_cur_reg, s1_sel_reg, s1_inset_reg, s1_par_reg;
    rc_t  s1_col_reg;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mem.oAddr    <= '0;
            s1_in_reg    <= 1'b0;
            s1_cur_reg   <= 1'b0;
            s1_sel_reg   <= 1'b0;
            s1_inset_reg <= 1'b0;
            s1_par_reg   <= 1'b0;
            s1_col_reg   <= '0;
        end else begin
            if (iValid && in_board)
                mem.oAddr <= ADDR_W'(BASE_ADDR) + ADDR_W'(board_row);
            s1_in_reg    <= in_board;
            s1_cur_reg   <= cursor_hit;
            s1_sel_reg   <= sel_hit;
            s1_inset_reg <= inset;
            s1_par_reg   <= board_row[0] ^ board_col[0];
            s1_col_reg   <= board_col;
        end
    end

    // Stage 2: piece extract from the row word
    logic [DATA_W-1:0]  row_word;
    logic [PIECE_W-1:0] s2_piece_reg;
    logic               s2_in_reg, s2_cur_reg, s2_sel_reg, s2_inset_reg, s2_par_reg;

    assign row_word = mem.iData;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s2_piece_reg <= '0;
            s2_in_reg    <= 1'b0;
            s2_cur_reg   <= 1'b0;
            s2_sel_reg   <= 1'b0;
            s2_inset_reg <= 1'b0;
            s2_par_reg   <= 1'b0;
        end else begin
            s2_piece_reg <= s1_in_reg ? PIECE_W'(row_word >> (int'(s1_col_reg) * PIECE_W)) : '0;
            s2_in_reg    <= s1_in_reg;
            s2_cur_reg   <= s1_cur_reg;
            s2_sel_reg   <= s1_sel_reg;
            s2_inset_reg <= s1_inset_reg;
            s2_par_reg   <= s1_par_reg;
        end
    end

    // Stage 3: colour priority
    logic [23:0] colour_next, rgb_reg;

    always_comb begin
        colour_next = 24'h000000;
        if (!s2_in_reg)
            colour_next = 24'h000000;
        else if (s2_cur_reg)
            colour_next = 24'hFF0000;
        else if ((s2_piece_reg != '0) && s2_inset_reg)
            colour_next = s2_piece_reg[PIECE_W-1] ? 24'h000000 : 24'hFFFFFF;
        else if (s2_sel_reg)
            colour_next = 24'h00A000;
        else
            colour_next = s2_par_reg ? 24'hB58863 : 24'hF0D9B5;
    end

    // Shared valid/hsync/vsync delay line, one register per pipeline stage
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic [2:0] stage_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge iCLK) begin
                if (iRST) stage_reg <= '0;
                else      stage_reg <= {iValid, iHS, iVS};
            end
        end else begin : g_rest
            always_ff @(posedge iCLK) begin
                if (iRST) stage_reg <= '0;
                else      stage_reg <= g_sync[gi-1].stage_reg;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) rgb_reg <= '0;
        else      rgb_reg <= g_sync[1].stage_reg[2] ? colour_next : 24'h000000;
    end

    assign oValid = g_sync[2].stage_reg[2];
    assign oHS    = g_sync[2].stage_reg[1];
    assign oVS    = g_sync[2].stage_reg[0];
    assign oR     = rgb_reg[23:16];
    assign oG     = rgb_reg[15:8];
    assign oB     = rgb_reg[7:0];
endmodule

// File: tb/tb_chess_board_render.sv
// Bench for chess_board_render: arithmetic board model checked every cycle,
// plus directed pixels with hand-computed colours and addresses.
module tb_chess_board_render;
    logic       clk = 1'b0;
    logic       rst, valid, hs, vs, fs, flip, cen, sen;
    logic [9:0] x, y;
    logic [2:0] crow, ccol, srow, scol;
    logic       ov, ohs, ovs;
    logic [7:0] r, g, b;

    always #5 clk = ~clk;

    chess_board_render_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    logic [31:0] mem_words [0:7];
    assign bus.iData = (bus.oAddr < 12'd8) ? mem_words[bus.oAddr[2:0]] : 32'h0;

    chess_board_render dut (
        .iCLK(clk), .iRST(rst), .iValid(valid), .iX(x), .iY(y), .iHS(hs), .iVS(vs),
        .iFrameStart(fs), .iFlip(flip), .iCursorEn(cen), .iCursorRow(crow), .iCursorCol(ccol),
        .iSelEn(sen), .iSelRow(srow), .iSelCol(scol), .mem(bus),
        .oValid(ov), .oR(r), .oG(g), .oB(b), .oHS(ohs), .oVS(ovs)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       v;
        logic       hs;
        logic       vs;
        logic [23:0] rgb;
    } px_t;

    px_t         m_pipe [0:2];
    logic [11:0] m_addr;
    logic        m_flip, m_cen, m_sen;
    int          m_crow, m_ccol, m_srow, m_scol, m_frames;

    function automatic bit on_board(int xx, int yy);
        return xx >= 64 && xx < 64 + 8 * 32 && yy >= 0 && yy < 8 * 32;
    endfunction

    function automatic int board_of(int scr);
        return m_flip ? 7 - scr : scr;
    endfunction

    function automatic px_t expect_px(logic v, int xx, int yy, logic h, logic vv);
        px_t p;
        int br, bc, lx, ly, piece;
        bit edge_px;
        p = '0;
        p.v = v; p.hs = h; p.vs = vv;
        if (!v || !on_board(xx, yy)) return p;
        br = board_of(yy / 32);
        bc = board_of((xx - 64) / 32);
        lx = (xx - 64) % 32;
        ly = yy % 32;
        piece = int'((mem_words[br] >> (4 * bc)) & 32'hF);
        edge_px = lx < 2 || lx > 29 || ly < 2 || ly > 29;
        if (m_cen && (m_frames % 64) < 32 && br == m_crow && bc == m_ccol && edge_px)
            p.rgb = 24'hFF0000;
        else if (piece != 0 && lx >= 6 && lx <= 25 && ly >= 6 && ly <= 25)
            p.rgb = (piece >= 8) ? 24'h000000 : 24'hFFFFFF;
        else if (m_sen && br == m_srow && bc == m_scol)
            p.rgb = 24'h00A000;
        else
            p.rgb = ((br + bc) % 2 == 0) ? 24'hF0D9B5 : 24'hB58863;
        return p;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pipe[0] <= '0; m_pipe[1] <= '0; m_pipe[2] <= '0;
            m_addr <= '0; m_flip <= 1'b0; m_cen <= 1'b0; m_sen <= 1'b0;
            m_crow <= 0; m_ccol <= 0; m_srow <= 0; m_scol <= 0; m_frames <= 0;
        end else begin
            m_pipe[0] <= expect_px(valid, int'(x), int'(y), hs, vs);
            m_pipe[1] <= m_pipe[0];
            m_pipe[2] <= m_pipe[1];
            if (valid && on_board(int'(x), int'(y)))
                m_addr <= 12'(board_of(int'(y) / 32));
            if (fs) begin
                m_flip <= flip; m_cen <= cen; m_sen <= sen;
                m_crow <= int'(crow); m_ccol <= int'(ccol);
                m_srow <= int'(srow); m_scol <= int'(scol);
                m_frames <= m_frames + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("cyc.oValid", 32'(ov), 32'(m_pipe[2].v));
        chk("cyc.oHS", 32'(ohs), 32'(m_pipe[2].hs));
        chk("cyc.oVS", 32'(ovs), 32'(m_pipe[2].vs));
        chk("cyc.rgb", {8'h0, r, g, b}, {8'h0, m_pipe[2].rgb});
        chk("cyc.oAddr", 32'(bus.oAddr), 32'(m_addr));
    endtask

    task automatic idle();
        valid = 1'b0; x = '0; y = '0; hs = 1'b0; vs = 1'b0; fs = 1'b0;
    endtask

    task automatic frame_pulse();
        fs = 1'b1; tick(); fs = 1'b0; tick();
    endtask

    task automatic px_lit(input string nm, input int xx, input int yy,
                          input logic [23:0] rgb, input logic [11:0] addr);
        valid = 1'b1; x = 10'(xx); y = 10'(yy);
        tick(); idle(); tick(); tick();
        chk({nm, ".valid"}, 32'(ov), 32'd1);
        chk({nm, ".rgb"}, {8'h0, r, g, b}, {8'h0, rgb});
        chk({nm, ".addr"}, 32'(bus.oAddr), 32'(addr));
    endtask

    initial begin
        rst = 1'b1; idle();
        flip = 1'b0; cen = 1'b0; sen = 1'b0;
        crow = '0; ccol = '0; srow = '0; scol = '0;
        for (int k = 0; k < 8; k++) mem_words[k] = 32'h0;
        mem_words[0] = 32'h0000_0009;
        mem_words[3] = 32'h000A_0000;
        mem_words[7] = 32'h2000_0000;

        tick(); tick();
        chk("reset.oValid", 32'(ov), 32'd0);
        chk("reset.rgb", {8'h0, r, g, b}, 32'd0);
        chk("reset.sync", {30'd0, ohs, ovs}, 32'd0);
        chk("reset.oAddr", 32'(bus.oAddr), 32'd0);
        rst = 1'b0;
        tick();

        // board origin and square colours
        px_lit("origin_piece", 80, 16, 24'h000000, 12'd0);
        px_lit("origin_light", 66, 2, 24'hF0D9B5, 12'd0);
        px_lit("origin_dark", 98, 2, 24'hB58863, 12'd0);
        px_lit("corner", 319, 255, 24'hF0D9B5, 12'd7);

        // outside the board: black, address held
        px_lit("edge_left", 63, 0, 24'h000000, 12'd7);
        px_lit("edge_right", 320, 0, 24'h000000, 12'd7);
        px_lit("edge_bottom", 64, 256, 24'h000000, 12'd7);

        // cursor blink
        cen = 1'b1; crow = 3'd0; ccol = 3'd0;
        px_lit("cursor_unlatched", 64, 0, 24'hF0D9B5, 12'd0);
        frame_pulse();
        px_lit("cursor_on", 64, 0, 24'hFF0000, 12'd0);
        repeat (31) frame_pulse();
        px_lit("cursor_off", 64, 0, 24'hF0D9B5, 12'd0);
        repeat (31) frame_pulse();
        px_lit("cursor_off_last", 64, 0, 24'hF0D9B5, 12'd0);
        frame_pulse();
        px_lit("cursor_wrap", 64, 0, 24'hFF0000, 12'd0);

        // priority: cursor + selection + piece on square (3,4)
        crow = 3'd3; ccol = 3'd4; sen = 1'b1; srow = 3'd3; scol = 3'd4;
        frame_pulse();
        px_lit("prio_border", 192, 97, 24'hFF0000, 12'd3);
        px_lit("prio_inset", 202, 106, 24'h000000, 12'd3);
        px_lit("prio_sel", 195, 99, 24'h00A000, 12'd3);
        px_lit("prio_neighbour", 227, 99, 24'hF0D9B5, 12'd3);

        // flip
        flip = 1'b1;
        frame_pulse();
        px_lit("flip_piece", 80, 16, 24'hFFFFFF, 12'd7);
        px_lit("flip_light", 66, 2, 24'hF0D9B5, 12'd7);
        flip = 1'b0;
        px_lit("flip_held", 80, 16, 24'hFFFFFF, 12'd7);

        // back-to-back stream with control changes and coincident frame pulses
        for (int k = 0; k < 8; k++) mem_words[k] = $urandom;
        tick();
        for (int i = 0; i < 600; i++) begin
            valid = ((i % 40) < 32);
            x  = 10'(40 + (i * 7) % 300);
            y  = 10'((i * 13) % 270);
            hs = ((i % 50) < 5);
            vs = ((i % 200) < 3);
            fs = (i % 23 == 0);
            flip = 1'($urandom_range(0, 1));
            cen  = ($urandom_range(0, 3) != 0);
            sen  = 1'($urandom_range(0, 1));
            crow = 3'($urandom_range(0, 7)); ccol = 3'($urandom_range(0, 7));
            srow = 3'($urandom_range(0, 7)); scol = 3'($urandom_range(0, 7));
            tick();
        end
        idle();
        tick(); tick(); tick();

        // reset in the middle of active pixels
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; x = 10'(70 + 9 * i); y = 10'(40 + 3 * i);
            tick();
        end
        rst = 1'b1;
        tick(); tick();
        chk("midrst.oValid", 32'(ov), 32'd0);
        chk("midrst.rgb", {8'h0, r, g, b}, 32'd0);
        chk("midrst.oAddr", 32'(bus.oAddr), 32'd0);
        rst = 1'b0; valid = 1'b1; x = 10'd80; y = 10'd16;
        tick();
        idle();
        chk("latency.c1", 32'(ov), 32'd0);
        tick();
        chk("latency.c2", 32'(ov), 32'd0);
        tick();
        chk("latency.c3", 32'(ov), 32'd1);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
